// File: rtl/csa_mult_seq_if.sv
// Operand/product interface for csa_mult_seq.
// Signed support is selected by the macro CSA_MULT_SIGNED_EN, which adds the tc signal.
// Handshake rules: a transfer happens on a rising edge where valid and ready are both 1.
// The producer holds valid and its payload stable until that edge.
// ready may not depend on valid in the same cycle.
interface csa_mult_seq_if #(
    parameter int WIDTH = 6
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
`ifdef CSA_MULT_SIGNED_EN
    logic               tc;
`endif
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] p;
    logic               busy;

    // Operand producer / product consumer side
    modport master (
        output in_valid, a, b,
`ifdef CSA_MULT_SIGNED_EN
        output tc,
`endif
        output out_ready,
        input  in_ready, out_valid, p, busy
    );

    // Multiplier side
    modport slave (
        input  in_valid, a, b,
`ifdef CSA_MULT_SIGNED_EN
        input  tc,
`endif
        input  out_ready,
        output in_ready, out_valid, p, busy
    );
endinterface

// File: rtl/csa_mult_seq.sv
// Sequential carry-save multiplier.
// Each ACC cycle folds PP_PER_CYCLE partial products into redundant sum and carry
// registers using 3:2 compressors only. One RESOLVE cycle then performs the single
// carry-propagate add.
// Macro CSA_MULT_SIGNED_EN enables the tc input. With it, tc=1 selects a
// Baugh-Wooley two's-complement product; without it, the product is always unsigned.
module csa_mult_seq #(
    parameter int WIDTH        = 6,
    parameter int PP_PER_CYCLE = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    csa_mult_seq_if.slave bus,
    output logic [1:0]    o_dbg_state
);
    localparam int N_ITER = WIDTH / PP_PER_CYCLE;
    localparam int CW     = (N_ITER > 1) ? $clog2(N_ITER) : 1;
    localparam int PW     = 2 * WIDTH;
    localparam logic [CW-1:0] LAST_ITER = CW'(N_ITER - 1);
    // The Baugh-Wooley correction is -2^(2W-1) + 2^W; modulo 2^(2W) it equals 2^(2W-1) + 2^W.
    localparam logic [PW-1:0] BW_CORR = (PW'(1) << (PW - 1)) | (PW'(1) << WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACC     = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_tc;
    logic [CW-1:0]     r_cnt;
    logic [PW-1:0]     r_sum;
    logic [PW-1:0]     r_carry;
    logic [PW-1:0]     r_p;
    logic [PW-1:0]     w_sum_nxt;
    logic [PW-1:0]     w_carry_nxt;
    logic              w_tc_in;

`ifdef CSA_MULT_SIGNED_EN
    assign w_tc_in = bus.tc;
`else
    assign w_tc_in = 1'b0;
`endif

    assign bus.p       = r_p;
    assign o_dbg_state = r_state;

    // Partial-product row 'row', aligned to its weight.
    // In signed mode, the MSB term of rows 0..W-2 is complemented.
    // In signed mode, the low terms of row W-1 are complemented.
    function automatic logic [PW-1:0] pp_row(input int row, input logic [WIDTH-1:0] a_v,
                                             input logic [WIDTH-1:0] b_v, input logic tc_v);
        logic [WIDTH-1:0] b_sh;
        logic [WIDTH-1:0] bits;
        b_sh = b_v >> row;
        bits = a_v & {WIDTH{b_sh[0]}};
        if (tc_v) begin
            if (row == WIDTH - 1) bits[WIDTH-2:0] = ~bits[WIDTH-2:0];
            else                  bits[WIDTH-1]   = ~bits[WIDTH-1];
        end
        return PW'(bits) << row;
    endfunction

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic and state-decoded handshake outputs
    always_comb begin
        w_state_nxt   = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) w_state_nxt = ST_ACC;
            end
            ST_ACC: begin
                bus.busy = 1'b1;
                if (r_cnt == LAST_ITER) w_state_nxt = ST_RESOLVE;
            end
            ST_RESOLVE: begin
                bus.busy    = 1'b1;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                bus.out_valid = 1'b1;
                // IDLE is reached only on the edge after the handshake, so no acceptance overlaps it
                if (bus.out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Carry-save step: chain 3:2 compressors over this cycle's rows plus the signed correction
    always_comb begin
        logic [PW-1:0] w_s;
        logic [PW-1:0] w_c;
        logic [PW-1:0] w_x;
        logic [PW-1:0] w_maj;
        w_s   = r_sum;
        w_c   = r_carry;
        w_x   = '0;
        w_maj = '0;
        for (int k = 0; k < PP_PER_CYCLE; k++) begin
            w_x   = pp_row(int'(r_cnt) * PP_PER_CYCLE + k, r_a, r_b, r_tc);
            w_maj = (w_s & w_c) | (w_s & w_x) | (w_c & w_x);
            w_s   = w_s ^ w_c ^ w_x;
            w_c   = w_maj << 1;
        end
        // The correction constant is injected once, in the first ACC cycle
        w_x         = (r_tc && (r_cnt == '0)) ? BW_CORR : '0;
        w_maj       = (w_s & w_c) | (w_s & w_x) | (w_c & w_x);
        w_sum_nxt   = w_s ^ w_c ^ w_x;
        w_carry_nxt = w_maj << 1;
    end

    // Operand capture, accumulation, final resolve and product hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_tc    <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_carry <= '0;
            r_p     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_tc    <= w_tc_in;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                        r_carry <= '0;
                    end
                end
                ST_ACC: begin
                    r_sum   <= w_sum_nxt;
                    r_carry <= w_carry_nxt;
                    r_cnt   <= r_cnt + 1'b1;
                end
                ST_RESOLVE: r_p <= r_sum + r_carry;
                default: ;
            endcase
        end
    end
endmodule
